// File: rtl/vdc_angle_if.sv
// Angle-stream interface between the van der Corput generator and its
// controller / downstream trig LUT stage.
interface vdc_angle_if #(
    parameter int KW = 32,
    parameter int AW = 16
);
    logic          start;
    logic [KW-1:0] seed;
    logic          halt;
    logic [AW-1:0] angle;
    logic          angle_valid;
    logic          angle_ready;
    logic [KW-1:0] index;
    logic          busy;

    // angle/index transfer on a cycle where angle_valid && angle_ready; while
    // angle_valid is high and not accepted, angle and index are held stable and
    // angle_valid is never withdrawn (only a start abort or reset clears it).
    modport master (
        output start, seed, halt, angle_ready,
        input  angle, angle_valid, index, busy
    );

    modport slave (
        input  start, seed, halt, angle_ready,
        output angle, angle_valid, index, busy
    );
endinterface

// File: rtl/vdc_angle_gen.sv
// Sequential base-BASE van der Corput angle generator: digit extraction of k
// followed by Horner accumulation gives angle = floor(vdc(k) * 2^AW) exactly.
module vdc_angle_gen #(
    parameter int BASE   = 2,
    parameter int KW     = 32,
    parameter int AW     = 16,
    parameter int DIGITS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    vdc_angle_if.slave bus,
    output logic [1:0] state_dbg
);
    localparam int DW   = $clog2(BASE);
    localparam int ACCW = AW + $clog2(BASE) + 1;
    localparam int NW   = $clog2(DIGITS + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0]   BASE_K = KW'(BASE);
    localparam logic [ACCW-1:0] BASE_A = ACCW'(BASE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGIT  = 2'd1,
        HORNER = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_work;
    logic [ACCW-1:0] acc;
    logic [NW-1:0]   ndig;
    logic [DW-1:0]   dbuf [DIGITS];
    logic            halt_pend;
    logic [AW-1:0]   angle_q;
    logic [KW-1:0]   index_q;
    logic            valid_q;

    logic [DW-1:0]   k_digit;
    logic [KW-1:0]   k_quot;
    logic [IW-1:0]   wr_ptr;
    logic [IW-1:0]   rd_ptr;
    logic [DW-1:0]   h_digit;
    logic [ACCW-1:0] acc_next;
    logic [KW-1:0]   k_inc;
    logic [KW-1:0]   seed_inc;

    // Constant-divisor / and %: power-of-two BASE collapses to shift and mask.
    always_comb begin
        k_digit  = DW'(k_work % BASE_K);
        k_quot   = k_work / BASE_K;
        wr_ptr   = IW'(ndig);
        rd_ptr   = IW'(ndig - NW'(1));
        h_digit  = dbuf[rd_ptr];
        acc_next = (acc + (ACCW'(h_digit) << AW)) / BASE_A;
        k_inc    = k + KW'(1);
        seed_inc = bus.seed + KW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            k_work    <= '0;
            acc       <= '0;
            ndig      <= '0;
            halt_pend <= 1'b0;
            angle_q   <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
        end else if (bus.start) begin
            // start loads from IDLE and also aborts any run in progress
            state     <= DIGIT;
            k         <= seed_inc;
            k_work    <= seed_inc;
            ndig      <= '0;
            halt_pend <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (state != IDLE && bus.halt) begin
                halt_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                end
                DIGIT: begin
                    if (k_work != '0) begin
                        dbuf[wr_ptr] <= k_digit;
                        k_work       <= k_quot;
                        ndig         <= ndig + NW'(1);
                    end else begin
                        acc   <= '0;
                        state <= HORNER;
                    end
                end
                HORNER: begin
                    // most significant digit of k is consumed first
                    if (ndig == '0) begin
                        angle_q <= acc[AW-1:0];
                        index_q <= k;
                        valid_q <= 1'b1;
                        state   <= OUT;
                    end else begin
                        acc  <= acc_next;
                        ndig <= ndig - NW'(1);
                        if (ndig == NW'(1)) begin
                            angle_q <= acc_next[AW-1:0];
                            index_q <= k;
                            valid_q <= 1'b1;
                            state   <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (valid_q && bus.angle_ready) begin
                        valid_q <= 1'b0;
                        if (halt_pend || bus.halt) begin
                            halt_pend <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            k      <= k_inc;
                            k_work <= k_inc;
                            ndig   <= '0;
                            state  <= DIGIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.angle       = angle_q;
    assign bus.index       = index_q;
    assign bus.angle_valid = valid_q;
    assign bus.busy        = (state != IDLE);
    assign state_dbg       = state;
endmodule

// File: tb/tb_vdc_angle_gen.sv
// Self-checking bench for vdc_angle_gen: BASE=2 and BASE=3 instances, table
// vectors, hand sequences for backpressure/halt/restart/reset, random runs.
module tb_vdc_angle_gen;
    localparam int KW = 32;
    localparam int AW = 16;

    typedef struct {
        int          sel;
        logic [31:0] seed;
        int          n;
        logic [31:0] idx [5];
        logic [15:0] ang [5];
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vdc_angle_if #(.KW(KW), .AW(AW)) bus2 ();
    vdc_angle_if #(.KW(KW), .AW(AW)) bus3 ();
    logic [1:0] st2;
    logic [1:0] st3;

    vdc_angle_gen #(.BASE(2), .KW(KW), .AW(AW), .DIGITS(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .state_dbg(st2)
    );
    vdc_angle_gen #(.BASE(3), .KW(KW), .AW(AW), .DIGITS(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .state_dbg(st3)
    );

    int checks = 0;
    int errors = 0;
    int got2   = 0;
    int got3   = 0;
    logic [47:0] exp_q2 [$];
    logic [47:0] exp_q3 [$];
    logic [47:0] e2;
    logic [47:0] e3;
    vec_t tbl [4];

    // ---------------- reference model ----------------
    // angle = floor(2^16 * r / BASE^n), r = digits of k reversed as an integer
    function automatic logic [15:0] ref_angle(input logic [31:0] k, input int base);
        longint unsigned r, den, kk;
        r = 0; den = 1; kk = longint'(k);
        while (kk != 0) begin
            r   = r * longint'(base) + (kk % longint'(base));
            den = den * longint'(base);
            kk  = kk / longint'(base);
        end
        return 16'((r << 16) / den);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && bus2.angle_valid && bus2.angle_ready && !bus2.start) begin
            got2++;
            if (exp_q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut2 sample: got index %0h angle %0d, expected none", bus2.index, bus2.angle);
            end else begin
                e2 = exp_q2.pop_front();
                check("dut2 sample {index,angle}", 64'({bus2.index, bus2.angle}), 64'(e2));
            end
        end
        if (rst_n && bus3.angle_valid && bus3.angle_ready && !bus3.start) begin
            got3++;
            if (exp_q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut3 sample: got index %0h angle %0d, expected none", bus3.index, bus3.angle);
            end else begin
                e3 = exp_q3.pop_front();
                check("dut3 sample {index,angle}", 64'({bus3.index, bus3.angle}), 64'(e3));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int got_of(input int sel);
        return (sel == 2) ? got2 : got3;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 2) ? bus2.busy : bus3.busy;
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 2) ? exp_q2.size() : exp_q3.size();
    endfunction

    task automatic set_ready(input int sel, input logic v);
        if (sel == 2) bus2.angle_ready = v;
        else          bus3.angle_ready = v;
    endtask

    task automatic set_halt(input int sel, input logic v);
        if (sel == 2) bus2.halt = v;
        else          bus3.halt = v;
    endtask

    task automatic pulse_start(input int sel, input logic [31:0] sd);
        if (sel == 2) begin bus2.seed = sd; bus2.start = 1'b1; end
        else          begin bus3.seed = sd; bus3.start = 1'b1; end
        tick();
        if (sel == 2) bus2.start = 1'b0;
        else          bus3.start = 1'b0;
    endtask

    task automatic push_raw(input int sel, input logic [31:0] k, input logic [15:0] a);
        if (sel == 2) exp_q2.push_back({k, a});
        else          exp_q3.push_back({k, a});
    endtask

    task automatic push_model(input int sel, input logic [31:0] k);
        push_raw(sel, k, ref_angle(k, sel));
    endtask

    // Let n samples (counted from g0) through, halting while the last is in flight.
    task automatic finish_run(input int sel, input int g0, input int n, input bit rnd);
        int c;
        c = 0;
        while (got_of(sel) < g0 + n - 1 && c < 3000) begin
            if (rnd) set_ready(sel, 1'($urandom_range(0, 1)));
            tick(); c++;
        end
        set_halt(sel, 1'b1); tick(); set_halt(sel, 1'b0);
        while (busy_of(sel) && c < 3000) begin
            if (rnd) set_ready(sel, 1'($urandom_range(0, 1)));
            tick(); c++;
        end
        check("run ends idle", 64'(busy_of(sel)), 64'd0);
        check("run sample count", 64'(got_of(sel) - g0), 64'(n));
        check("run queue drained", 64'(qsize(sel)), 64'd0);
    endtask

    task automatic run(input int sel, input logic [31:0] sd, input int n, input bit rnd);
        int g0;
        g0 = got_of(sel);
        set_ready(sel, 1'b1);
        pulse_start(sel, sd);
        finish_run(sel, g0, n, rnd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int c;
        int g0;
        bus2.start = 1'b0; bus2.seed = '0; bus2.halt = 1'b0; bus2.angle_ready = 1'b0;
        bus3.start = 1'b0; bus3.seed = '0; bus3.halt = 1'b0; bus3.angle_ready = 1'b0;

        tbl[0].sel = 2; tbl[0].seed = 32'h0; tbl[0].n = 5;
        tbl[0].idx = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        tbl[0].ang = '{16'd32768, 16'd16384, 16'd49152, 16'd8192, 16'd40960};
        tbl[1].sel = 3; tbl[1].seed = 32'h0; tbl[1].n = 5;
        tbl[1].idx = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        tbl[1].ang = '{16'd21845, 16'd43690, 16'd7281, 16'd29127, 16'd50972};
        tbl[2].sel = 2; tbl[2].seed = 32'hFFFF_FFFE; tbl[2].n = 3;
        tbl[2].idx = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd0};
        tbl[2].ang = '{16'd65535, 16'd0, 16'd32768, 16'd0, 16'd0};
        tbl[3].sel = 3; tbl[3].seed = 32'd8; tbl[3].n = 2;
        tbl[3].idx = '{32'd9, 32'd10, 32'd0, 32'd0, 32'd0};
        tbl[3].ang = '{16'd2427, 16'd24272, 16'd0, 16'd0, 16'd0};

        rst_n = 1'b0;
        repeat (3) tick();
        check("reset dut2 {valid,busy,index,angle}",
              64'({bus2.angle_valid, bus2.busy, bus2.index, bus2.angle}), 64'd0);
        check("reset dut3 {valid,busy,index,angle}",
              64'({bus3.angle_valid, bus3.busy, bus3.index, bus3.angle}), 64'd0);
        check("reset dut2 state", 64'(st2), 64'd0);
        check("reset dut3 state", 64'(st3), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < tbl[i].n; j++) push_raw(tbl[i].sel, tbl[i].idx[j], tbl[i].ang[j]);
            run(tbl[i].sel, tbl[i].seed, tbl[i].n, 1'b0);
        end

        // latency, backpressure on sample 2, halt during HORNER of sample 4
        g0 = got2;
        for (int j = 1; j <= 4; j++) push_model(2, 32'(j));
        set_ready(2, 1'b1);
        pulse_start(2, 32'd0);
        c = 0;
        while (!bus2.angle_valid && c < 20) begin tick(); c++; end
        check("first valid latency", 64'(c), 64'd3);
        c = 0;
        while (got2 < g0 + 1 && c < 50) begin tick(); c++; end
        set_ready(2, 1'b0);
        c = 0;
        while (!bus2.angle_valid && c < 50) begin tick(); c++; end
        for (int j = 0; j < 10; j++) begin
            tick();
            check("backpressure hold {valid,index,angle}",
                  64'({bus2.angle_valid, bus2.index, bus2.angle}), 64'({1'b1, 32'd2, 16'd16384}));
        end
        check("backpressure nothing skipped", 64'(got2 - g0), 64'd1);
        set_ready(2, 1'b1);
        c = 0;
        while (got2 < g0 + 3 && c < 100) begin tick(); c++; end
        c = 0;
        while (st2 != 2'd2 && c < 50) begin tick(); c++; end
        check("sample 4 in HORNER", 64'(st2), 64'd2);
        set_halt(2, 1'b1); tick(); set_halt(2, 1'b0);
        c = 0;
        while (bus2.busy && c < 50) begin tick(); c++; end
        check("halt -> idle", 64'(bus2.busy), 64'd0);
        check("halt delivered sample 4", 64'(got2 - g0), 64'd4);

        // start together with halt while busy: restart wins
        g0 = got2;
        set_ready(2, 1'b0);
        pulse_start(2, 32'd10);
        c = 0;
        while (!bus2.angle_valid && c < 50) begin tick(); c++; end
        check("valid before restart", 64'(bus2.angle_valid), 64'd1);
        bus2.seed = 32'd200; bus2.start = 1'b1; bus2.halt = 1'b1;
        tick();
        bus2.start = 1'b0; bus2.halt = 1'b0;
        check("restart {valid,busy}", 64'({bus2.angle_valid, bus2.busy}), 64'b01);
        for (int j = 1; j <= 3; j++) push_model(2, 32'(200 + j));
        set_ready(2, 1'b1);
        finish_run(2, g0, 3, 1'b0);

        // reset mid-DIGIT
        set_ready(2, 1'b1);
        pulse_start(2, 32'd7);
        tick();
        check("mid-DIGIT state", 64'(st2), 64'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("mid-run reset {valid,busy,index,angle}",
              64'({bus2.angle_valid, bus2.busy, bus2.index, bus2.angle}), 64'd0);
        check("mid-run reset state", 64'(st2), 64'd0);
        push_raw(2, 32'd1, 16'd32768);
        run(2, 32'd0, 1, 1'b0);

        // random seeds and random backpressure
        for (int r = 0; r < 8; r++) begin
            int          sel;
            int          n;
            logic [31:0] sd;
            sel = (r % 2 == 0) ? 2 : 3;
            sd  = $urandom;
            if (r >= 6) sd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            n = $urandom_range(2, 5);
            for (int j = 1; j <= n; j++) push_model(sel, sd + 32'(j));
            run(sel, sd, n, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
